// File: rtl/im_stack_queue_pkg.sv
// Shared encodings for the move-history buffer (package im_pkg).
package im_pkg;
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam int SQ_DEPTH = 256;

  typedef enum logic [1:0] {STACK, DRAIN, FINISH} sq_state_t;
endpackage

// File: rtl/im_sq_mem.sv
// Move storage: one synchronous write port, two asynchronous read ports
// (stack top and replay pointer). Contents are never reset.
module im_sq_mem
  import im_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int DW    = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] top_addr,
  input  logic [AW-1:0] move_addr,
  output logic [DW-1:0] top_data,
  output logic [DW-1:0] move_data
);
  logic [DEPTH-1:0][DW-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign top_data  = mem[top_addr];
  assign move_data = mem[move_addr];
endmodule

// File: rtl/im_stack_queue.sv
// Move-history buffer: LIFO during search, oldest-first replay afterwards.
// Optional sticky overflow flag enabled by defining IM_SQ_OVERFLOW_EN.
module im_stack_queue
  import im_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int DW    = 2
) (
  input  logic          CLK,
  input  logic          Rst,
  input  logic          rstDP,
  input  logic          pushSQ,
  input  logic          popSQ,
  input  logic [DW-1:0] SQ_Input,
  input  logic          SQ_Read,
  output logic [DW-1:0] topValueSQ,
  output logic [DW-1:0] moveOut,
  output logic          SQ_Empty,
  output logic          SQ_Full,
  output logic          SQ_Done,
  output logic          SQ_Ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sq_state_t     state;
  logic [CW-1:0] sp, rp, rp_nx;
  logic          push_only, replace, cmd_ok, we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] top_data;

  assign SQ_Empty  = (sp == '0);
  assign SQ_Full   = (sp == CW'(DEPTH));
  assign rp_nx     = rp + 1'b1;
  // push+pop on an empty stack degrades to a plain push
  assign push_only = pushSQ & (~popSQ | SQ_Empty);
  assign replace   = pushSQ & popSQ & ~SQ_Empty;
  assign cmd_ok    = (state == STACK) & ~SQ_Read & ~rstDP;
  assign we        = cmd_ok & ((push_only & ~SQ_Full) | replace);
  assign waddr     = replace ? AW'(sp - 1'b1) : AW'(sp);

  im_sq_mem #(.DEPTH(DEPTH), .DW(DW)) u_mem (
    .clk       (CLK),
    .we        (we),
    .waddr     (waddr),
    .wdata     (SQ_Input),
    .top_addr  (AW'(sp - 1'b1)),
    .move_addr (AW'(rp)),
    .top_data  (top_data),
    .move_data (moveOut)
  );

  assign topValueSQ = SQ_Empty ? '0 : top_data;

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state   <= STACK;
      sp      <= '0;
      rp      <= '0;
      SQ_Done <= 1'b0;
    end else if (rstDP) begin
      state   <= STACK;
      sp      <= '0;
      rp      <= '0;
      SQ_Done <= 1'b0;
    end else begin
      SQ_Done <= 1'b0;
      case (state)
        STACK: begin
          if (SQ_Read) begin
            // entry 0 is consumed on this edge; a 0/1-entry stack is done at once
            if (sp <= CW'(1)) begin
              state   <= FINISH;
              rp      <= sp;
              SQ_Done <= 1'b1;
            end else begin
              state <= DRAIN;
              rp    <= CW'(1);
            end
          end else if (replace) begin
            sp <= sp;
          end else if (push_only) begin
            if (!SQ_Full) sp <= sp + 1'b1;
          end else if (popSQ && !SQ_Empty) begin
            sp <= sp - 1'b1;
          end
        end
        DRAIN: begin
          if (SQ_Read) begin
            if (rp_nx >= sp) begin
              state   <= FINISH;
              rp      <= sp;
              SQ_Done <= 1'b1;
            end else begin
              rp <= rp_nx;
            end
          end
        end
        FINISH: begin
          state <= DRAIN;
          rp    <= '0;
        end
        default: state <= STACK;
      endcase
    end
  end

`ifdef IM_SQ_OVERFLOW_EN
  logic ovf;
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst)                                ovf <= 1'b0;
    else if (rstDP)                         ovf <= 1'b0;
    else if (cmd_ok && push_only && SQ_Full) ovf <= 1'b1;
  end
  assign SQ_Ovf = ovf;
`else
  assign SQ_Ovf = 1'b0;
`endif
endmodule

// File: tb/tb_im_stack_queue.sv
// Bench for im_stack_queue: directed plan plus random traffic against a
// queue-based reference model.
module tb_im_stack_queue;
  import im_pkg::*;
  localparam int DEPTH = SQ_DEPTH;
  localparam int DW    = 2;
`ifdef IM_SQ_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          Rst, rstDP, pushSQ, popSQ, SQ_Read;
  logic [DW-1:0] SQ_Input;
  logic [DW-1:0] topValueSQ, moveOut;
  logic          SQ_Empty, SQ_Full, SQ_Done, SQ_Ovf;

  always #5 CLK = ~CLK;

  im_stack_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .CLK(CLK), .Rst(Rst), .rstDP(rstDP), .pushSQ(pushSQ), .popSQ(popSQ),
    .SQ_Input(SQ_Input), .SQ_Read(SQ_Read), .topValueSQ(topValueSQ),
    .moveOut(moveOut), .SQ_Empty(SQ_Empty), .SQ_Full(SQ_Full),
    .SQ_Done(SQ_Done), .SQ_Ovf(SQ_Ovf)
  );

  // reference model: stored path as a queue, replay cursor, phase
  logic [DW-1:0] q[$];
  int  rp;
  int  mode;  // 0 searching, 1 replaying, 2 replay just finished
  bit  done, ovf;
  int  passed = 0, total = 0;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_rst();
    q.delete(); rp = 0; mode = 0; done = 0; ovf = 0;
  endtask

  task automatic check_all();
    chk("empty", 8'(SQ_Empty), 8'(q.size() == 0));
    chk("full",  8'(SQ_Full),  8'(q.size() == DEPTH));
    chk("top",   8'(topValueSQ), (q.size() == 0) ? 8'h0 : 8'(q[q.size()-1]));
    chk("done",  8'(SQ_Done), 8'(done));
    chk("ovf",   8'(SQ_Ovf),  8'(ovf));
    if (rp < q.size()) chk("move", 8'(moveOut), 8'(q[rp]));
  endtask

  task automatic model_step(bit p, bit o, logic [DW-1:0] d, bit r, bit c);
    if (c) begin
      model_rst();
      return;
    end
    case (mode)
      0: begin
        if (r) begin
          if (q.size() <= 1) begin mode = 2; rp = q.size(); end
          else begin mode = 1; rp = 1; end
        end else if (p && o && q.size() > 0) q[q.size()-1] = d;
        else if (p) begin
          if (q.size() < DEPTH) q.push_back(d);
          else if (OVF_EN) ovf = 1;
        end else if (o && q.size() > 0) void'(q.pop_back());
      end
      1: if (r) begin
        rp++;
        if (rp >= q.size()) begin rp = q.size(); mode = 2; end
      end
      default: begin mode = 1; rp = 0; end
    endcase
    done = (mode == 2);
  endtask

  task automatic step(bit p, bit o, logic [DW-1:0] d, bit r, bit c = 0);
    @(negedge CLK);
    check_all();
    pushSQ = p; popSQ = o; SQ_Input = d; SQ_Read = r; rstDP = c;
    model_step(p, o, d, r, c);
    @(posedge CLK);
  endtask

  initial begin
    Rst = 1; rstDP = 0; pushSQ = 0; popSQ = 0; SQ_Read = 0; SQ_Input = '0;
    model_rst();
    #12 Rst = 0;

    // basic push/pop, pop on empty, replace-top
    step(1, 0, DIR_UP, 0);
    step(1, 0, DIR_RIGHT, 0);
    step(1, 0, DIR_DOWN, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, DIR_RIGHT, 0);
    step(1, 1, DIR_LEFT, 0);
    step(1, 1, DIR_DOWN, 0);

    // replay twice with a gap, reads held through FINISH
    step(0, 0, 0, 0, 1);
    step(1, 0, DIR_RIGHT, 0);
    step(1, 0, DIR_RIGHT, 0);
    step(1, 0, DIR_DOWN, 0);
    step(1, 0, DIR_LEFT, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, DIR_UP, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // fill past capacity
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, DW'($urandom), 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // asynchronous reset in the middle of a replay
    step(1, 0, DIR_LEFT, 0);
    step(1, 0, DIR_DOWN, 0);
    step(1, 0, DIR_RIGHT, 0);
    step(1, 0, DIR_UP, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    @(negedge CLK);
    check_all();
    SQ_Read = 0;
    #2 Rst = 1;
    #1 model_rst();
    check_all();
    @(negedge CLK);
    #1 Rst = 0;
    step(1, 0, DIR_DOWN, 0);
    step(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int rnd;
      rnd = $urandom_range(0, 99);
      if (rnd < 2)       step(0, 0, 0, 0, 1);
      else if (rnd < 12) step(bit'($urandom), bit'($urandom), DW'($urandom), 1);
      else if (rnd < 45) step(1, 0, DW'($urandom), 0);
      else if (rnd < 65) step(0, 1, DW'($urandom), 0);
      else if (rnd < 75) step(1, 1, DW'($urandom), 0);
      else               step(0, 0, DW'($urandom), 0);
    end

    @(negedge CLK);
    check_all();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
